// File: rtl/pb_i2c_arbiter.sv
// rtl/pb_i2c_arbiter.sv - shares the power-board I2C master between the CAM path and a periodic battery poller
module pb_i2c_arbiter #(
    parameter int unsigned POLL_SECS   = 16,
    parameter logic [3:0]  POLL_TYPE   = 4'd2,
    parameter logic [7:0]  POLL_ADDR   = 8'h59,
    parameter logic [7:0]  POLL_REG    = 8'h0A,
    parameter int unsigned TIMEOUT_CYC = 2**24
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       sec_tick,
    input  logic       poll_en,
    input  logic       cam_start,
    input  logic [3:0] cam_type,
    input  logic [7:0] cam_arg0,
    input  logic [7:0] cam_arg1,
    input  logic [7:0] cam_pay0,
    input  logic [7:0] cam_pay1,
    output logic       cam_status,
    output logic [7:0] cam_rd_data0,
    output logic [7:0] cam_rd_data1,
    output logic       m_start,
    output logic [3:0] m_type,
    output logic [7:0] m_arg0,
    output logic [7:0] m_arg1,
    output logic [7:0] m_pay0,
    output logic [7:0] m_pay1,
    input  logic       m_status,
    input  logic [7:0] m_rd_data0,
    input  logic [7:0] m_rd_data1,
    output logic [7:0] bat_data0,
    output logic [7:0] bat_data1,
    output logic       bat_valid,
    output logic [7:0] poll_seq,
    output logic       timeout_err
);
    localparam int unsigned      WD_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       SECS_LAST = 8'(POLL_SECS - 1);

    typedef enum logic [2:0] {IDLE, C_START, C_BUSY, P_START, P_BUSY} state_t;

    state_t          state_q, state_d;
    logic [7:0]      timer_q, timer_d;
    logic            pend_q, pend_d, pend_clr;
    logic            last_poll_q, last_poll_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            m_start_q, m_start_d, cam_status_q, cam_status_d;
    logic [3:0]      m_type_q, m_type_d;
    logic [7:0]      m_arg0_q, m_arg0_d, m_arg1_q, m_arg1_d, m_pay0_q, m_pay0_d, m_pay1_q, m_pay1_d;
    logic [7:0]      cam_rd0_q, cam_rd0_d, cam_rd1_q, cam_rd1_d;
    logic [7:0]      bat0_q, bat0_d, bat1_q, bat1_d, seq_q, seq_d;
    logic            bat_valid_q, bat_valid_d, terr_q, terr_d;
    logic            grant_cam, grant_poll, is_cam;

    // Poll period timer; a period ending while a poll is still pending is simply absorbed.
    always_comb begin
        timer_d = timer_q;
        pend_d  = pend_q;
        if (!poll_en) begin
            timer_d = '0;
            pend_d  = 1'b0;
        end else begin
            if (pend_clr) pend_d = 1'b0;
            if (sec_tick) begin
                if (timer_q == SECS_LAST) begin
                    timer_d = '0;
                    pend_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_poll_d  = last_poll_q;
        wd_d         = '0;
        m_start_d    = m_start_q;
        cam_status_d = cam_status_q;
        m_type_d     = m_type_q;
        m_arg0_d     = m_arg0_q;
        m_arg1_d     = m_arg1_q;
        m_pay0_d     = m_pay0_q;
        m_pay1_d     = m_pay1_q;
        cam_rd0_d    = cam_rd0_q;
        cam_rd1_d    = cam_rd1_q;
        bat0_d       = bat0_q;
        bat1_d       = bat1_q;
        bat_valid_d  = bat_valid_q;
        seq_d        = seq_q;
        terr_d       = terr_q;
        pend_clr     = 1'b0;
        grant_cam    = 1'b0;
        grant_poll   = 1'b0;
        is_cam       = (state_q == C_START) || (state_q == C_BUSY);

        case (state_q)
            IDLE: begin
                m_start_d    = 1'b0;
                cam_status_d = 1'b0;
                // Hold off one cycle after a timeout pulse so a still-asserted cam_start is not re-granted.
                if (!cam_status_q) begin
                    grant_cam  = cam_start && (!pend_q || last_poll_q);
                    grant_poll = pend_q && !grant_cam;
                end
                if (grant_cam) begin
                    state_d     = C_START;
                    m_start_d   = 1'b1;
                    last_poll_d = 1'b0;
                    m_type_d    = cam_type;
                    m_arg0_d    = cam_arg0;
                    m_arg1_d    = cam_arg1;
                    m_pay0_d    = cam_pay0;
                    m_pay1_d    = cam_pay1;
                end else if (grant_poll) begin
                    state_d     = P_START;
                    m_start_d   = 1'b1;
                    last_poll_d = 1'b1;
                    m_type_d    = POLL_TYPE;
                    m_arg0_d    = POLL_REG;
                    m_arg1_d    = POLL_ADDR;
                    m_pay0_d    = 8'h00;
                    m_pay1_d    = 8'h00;
                end
            end
            C_START, P_START, C_BUSY, P_BUSY: begin
                wd_d = wd_q + 1'b1;
                if (wd_q == WD_LAST) begin
                    state_d   = IDLE;
                    m_start_d = 1'b0;
                    terr_d    = 1'b1;
                    if (is_cam) cam_status_d = 1'b1;
                    else        pend_clr     = 1'b1;
                end else if ((state_q == C_START) || (state_q == P_START)) begin
                    if (m_status) begin
                        m_start_d = 1'b0;
                        state_d   = is_cam ? C_BUSY : P_BUSY;
                        if (is_cam) cam_status_d = 1'b1;
                    end
                end else if (!m_status) begin
                    state_d = IDLE;
                    if (is_cam) begin
                        cam_status_d = 1'b0;
                        cam_rd0_d    = m_rd_data0;
                        cam_rd1_d    = m_rd_data1;
                    end else begin
                        bat0_d      = m_rd_data0;
                        bat1_d      = m_rd_data1;
                        bat_valid_d = 1'b1;
                        seq_d       = seq_q + 8'd1;
                        pend_clr    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            pend_q       <= 1'b0;
            last_poll_q  <= 1'b0;
            wd_q         <= '0;
            m_start_q    <= 1'b0;
            cam_status_q <= 1'b0;
            m_type_q     <= '0;
            m_arg0_q     <= '0;
            m_arg1_q     <= '0;
            m_pay0_q     <= '0;
            m_pay1_q     <= '0;
            cam_rd0_q    <= '0;
            cam_rd1_q    <= '0;
            bat0_q       <= '0;
            bat1_q       <= '0;
            bat_valid_q  <= 1'b0;
            seq_q        <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pend_q       <= pend_d;
            last_poll_q  <= last_poll_d;
            wd_q         <= wd_d;
            m_start_q    <= m_start_d;
            cam_status_q <= cam_status_d;
            m_type_q     <= m_type_d;
            m_arg0_q     <= m_arg0_d;
            m_arg1_q     <= m_arg1_d;
            m_pay0_q     <= m_pay0_d;
            m_pay1_q     <= m_pay1_d;
            cam_rd0_q    <= cam_rd0_d;
            cam_rd1_q    <= cam_rd1_d;
            bat0_q       <= bat0_d;
            bat1_q       <= bat1_d;
            bat_valid_q  <= bat_valid_d;
            seq_q        <= seq_d;
            terr_q       <= terr_d;
        end
    end

    assign m_start      = m_start_q;
    assign cam_status   = cam_status_q;
    assign m_type       = m_type_q;
    assign m_arg0       = m_arg0_q;
    assign m_arg1       = m_arg1_q;
    assign m_pay0       = m_pay0_q;
    assign m_pay1       = m_pay1_q;
    assign cam_rd_data0 = cam_rd0_q;
    assign cam_rd_data1 = cam_rd1_q;
    assign bat_data0    = bat0_q;
    assign bat_data1    = bat1_q;
    assign bat_valid    = bat_valid_q;
    assign poll_seq     = seq_q;
    assign timeout_err  = terr_q;
endmodule
